// File: rtl/sram_port_arbiter.sv
// Cycle-level arbiter sharing one single-port SRAM between the serial loader (l) and the CPU (c).
// Define SRAM_ARB_FIXED_PRI_EN to make the loader win every tie instead of round robin.
module sram_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned STARVE_MAX = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  l_req,
    input  logic                  l_we,
    input  logic                  l_lock,
    input  logic [ADDR_WIDTH-1:0] l_addr,
    input  logic [DATA_WIDTH-1:0] l_wdata,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    output logic                  l_gnt,
    output logic                  c_gnt,
    output logic                  l_rvalid,
    output logic                  c_rvalid,
    output logic [DATA_WIDTH-1:0] l_rdata,
    output logic [DATA_WIDTH-1:0] c_rdata,
    output logic                  sram_cen,
    output logic                  sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q,
    output logic                  starved
);

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    logic                  lock_q, lock_d;
    logic [3:0]            starve_q, starve_d;
    logic                  rd_pend_l_q, rd_pend_c_q;
    logic [DATA_WIDTH-1:0] l_rdata_q, c_rdata_q;
    logic                  force_c;
    logic                  tie_to_l;

`ifndef SRAM_ARB_FIXED_PRI_EN
    typedef enum logic {OwnL, OwnC} owner_e;
    owner_e last_owner_q, last_owner_d;
`endif

    // Grant decision; the forced CPU grant outranks the loader's burst lock.
    always_comb begin
        force_c = rst_n && c_req && (starve_q == StarveMax);
`ifdef SRAM_ARB_FIXED_PRI_EN
        tie_to_l = 1'b1;
`else
        tie_to_l = (last_owner_q == OwnC);
`endif
        l_gnt = 1'b0;
        c_gnt = 1'b0;
        if (!rst_n) begin
            l_gnt = 1'b0;
            c_gnt = 1'b0;
        end else if (force_c) begin
            c_gnt = 1'b1;
        end else if (lock_q && l_req) begin
            l_gnt = 1'b1;
        end else if (l_req && c_req) begin
            l_gnt = tie_to_l;
            c_gnt = !tie_to_l;
        end else begin
            l_gnt = l_req;
            c_gnt = c_req;
        end
        starved = force_c;
    end

    always_comb begin
        sram_cen = !(l_gnt || c_gnt);
        sram_wen = 1'b1;
        sram_a   = '0;
        sram_d   = '0;
        if (l_gnt) begin
            sram_wen = !l_we;
            sram_a   = l_addr;
            sram_d   = l_wdata;
        end else if (c_gnt) begin
            sram_wen = !c_we;
            sram_a   = c_addr;
            sram_d   = c_wdata;
        end
    end

    always_comb begin
        lock_d = lock_q;
        if (l_gnt || c_gnt) begin
            lock_d = l_gnt && l_lock;
        end else if (!l_lock) begin
            lock_d = 1'b0;
        end
        starve_d = '0;
        if (c_req && !c_gnt) begin
            starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'd1;
        end
`ifndef SRAM_ARB_FIXED_PRI_EN
        last_owner_d = last_owner_q;
        if (l_gnt) begin
            last_owner_d = OwnL;
        end else if (c_gnt) begin
            last_owner_d = OwnC;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q      <= 1'b0;
            starve_q    <= '0;
            rd_pend_l_q <= 1'b0;
            rd_pend_c_q <= 1'b0;
            l_rdata_q   <= '0;
            c_rdata_q   <= '0;
        end else begin
            lock_q      <= lock_d;
            starve_q    <= starve_d;
            rd_pend_l_q <= l_gnt && !l_we;
            rd_pend_c_q <= c_gnt && !c_we;
            if (rd_pend_l_q) begin
                l_rdata_q <= sram_q;
            end
            if (rd_pend_c_q) begin
                c_rdata_q <= sram_q;
            end
        end
    end

`ifndef SRAM_ARB_FIXED_PRI_EN
    // Loader wins the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= OwnC;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`endif

    // SRAM_Q is live in the cycle after the read; the register holds it afterwards.
    assign l_rvalid = rd_pend_l_q;
    assign c_rvalid = rd_pend_c_q;
    assign l_rdata  = rd_pend_l_q ? sram_q : l_rdata_q;
    assign c_rdata  = rd_pend_c_q ? sram_q : c_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus random traffic against a
// rule-level reference model and a behavioural SRAM.
module tb_sram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       l_req, l_we, l_lock, c_req, c_we;
    logic [8:0] l_addr, c_addr;
    logic [7:0] l_wdata, c_wdata;
    logic       l_gnt, c_gnt, l_rvalid, c_rvalid, sram_cen, sram_wen, starved;
    logic [7:0] l_rdata, c_rdata, sram_d, sram_q;
    logic [8:0] sram_a;

    int checks   = 0;
    int failures = 0;

    sram_port_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .l_req    (l_req),
        .l_we     (l_we),
        .l_lock   (l_lock),
        .l_addr   (l_addr),
        .l_wdata  (l_wdata),
        .c_req    (c_req),
        .c_we     (c_we),
        .c_addr   (c_addr),
        .c_wdata  (c_wdata),
        .l_gnt    (l_gnt),
        .c_gnt    (c_gnt),
        .l_rvalid (l_rvalid),
        .c_rvalid (c_rvalid),
        .l_rdata  (l_rdata),
        .c_rdata  (c_rdata),
        .sram_cen (sram_cen),
        .sram_wen (sram_wen),
        .sram_a   (sram_a),
        .sram_d   (sram_d),
        .sram_q   (sram_q),
        .starved  (starved)
    );

    always #5 clk = ~clk;

    // Behavioural single-port SRAM with registered read data.
    logic [7:0] sram_mem [512];
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) sram_mem[sram_a] <= sram_d;
            else           sram_q <= sram_mem[sram_a];
        end
    end

    // Reference model: arbitration rules in plain form, memory contents as an array.
    logic [7:0] ref_mem [512];
    bit         m_last_was_c;
    bit         m_lock;
    int         m_starve;
    bit         m_pend_l, m_pend_c;
    logic [7:0] m_pend_l_data, m_pend_c_data, m_held_l, m_held_c;

    function automatic logic [7:0] init_val(input int a);
        return 8'(a * 37 + 11);
    endfunction

    task automatic model_reset();
        m_last_was_c = 1'b1;
        m_lock       = 1'b0;
        m_starve     = 0;
        m_pend_l     = 1'b0;
        m_pend_c     = 1'b0;
        m_held_l     = 8'h00;
        m_held_c     = 8'h00;
    endtask

    task automatic decide(output bit gl, output bit gc, output bit forced);
        gl = 1'b0;
        gc = 1'b0;
        forced = 1'b0;
        if (rst_n === 1'b1) begin
            if (m_starve == 15 && c_req) begin
                gc = 1'b1;
                forced = 1'b1;
            end else if (m_lock && l_req) begin
                gl = 1'b1;
            end else if (l_req && c_req) begin
`ifdef SRAM_ARB_FIXED_PRI_EN
                gl = 1'b1;
`else
                gl = m_last_was_c;
                gc = !m_last_was_c;
`endif
            end else begin
                gl = l_req;
                gc = c_req;
            end
        end
    endtask

    task automatic model_update(input bit gl, input bit gc);
        if (rst_n !== 1'b1) begin
            model_reset();
            return;
        end
        if (m_pend_l) m_held_l = m_pend_l_data;
        if (m_pend_c) m_held_c = m_pend_c_data;
        m_pend_l = gl && !l_we;
        m_pend_c = gc && !c_we;
        if (m_pend_l) m_pend_l_data = ref_mem[l_addr];
        if (m_pend_c) m_pend_c_data = ref_mem[c_addr];
        if (gl && l_we) ref_mem[l_addr] = l_wdata;
        if (gc && c_we) ref_mem[c_addr] = c_wdata;
        if (gl) m_last_was_c = 1'b0;
        if (gc) m_last_was_c = 1'b1;
        if (gl || gc) m_lock = gl && l_lock;
        else if (!l_lock) m_lock = 1'b0;
        m_starve = (c_req && !gc) ? ((m_starve < 15) ? m_starve + 1 : 15) : 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs were driven at the preceding negedge.
    task automatic step(input bit auto_drop, input bit rst_after_edge);
        bit gl, gc, st;
        #1;
        decide(gl, gc, st);
        check("l_gnt", l_gnt, gl);
        check("c_gnt", c_gnt, gc);
        check("starved", starved, st);
        check("sram_cen", sram_cen, !(gl || gc));
        check("sram_wen", sram_wen, gl ? !l_we : (gc ? !c_we : 1'b1));
        check("sram_a", sram_a, gl ? l_addr : (gc ? c_addr : 9'h0));
        check("sram_d", sram_d, gl ? l_wdata : (gc ? c_wdata : 8'h0));
        check("l_rvalid", l_rvalid, m_pend_l);
        check("c_rvalid", c_rvalid, m_pend_c);
        check("l_rdata", l_rdata, m_pend_l ? m_pend_l_data : m_held_l);
        check("c_rdata", c_rdata, m_pend_c ? m_pend_c_data : m_held_c);
        @(posedge clk);
        model_update(gl, gc);
        if (rst_after_edge) begin
            #1;
            rst_n = 1'b0;
            model_reset();
        end
        @(negedge clk);
        if (auto_drop) begin
            if (gl) l_req = 1'b0;
            if (gc) c_req = 1'b0;
        end
    endtask

    function automatic logic [8:0] rand_addr();
        return ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 15));
    endfunction

    int  n_l;
    bit  got_c, st_seen;

    initial begin
        for (int i = 0; i < 512; i++) begin
            sram_mem[i] = init_val(i);
            ref_mem[i]  = init_val(i);
        end
        model_reset();
        rst_n = 1'b0;
        {l_req, l_we, l_lock, c_req, c_we} = 5'b10010;
        l_addr = 9'h010; c_addr = 9'h020; l_wdata = 8'h00; c_wdata = 8'h00;

        // Reset held with both requesting: nothing granted.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rst_l_gnt", l_gnt, 1'b0);
            check("rst_cen", sram_cen, 1'b1);
            step(1'b0, 1'b0);
        end

        // First tie after reset goes to the loader, then the CPU.
        rst_n = 1'b1;
        #1;
        check("first_tie_l", l_gnt, 1'b1);
        step(1'b1, 1'b0);
        check("l_rvalid_first", l_rvalid, 1'b1);
        check("l_rdata_first", l_rdata, init_val(9'h010));
        check("c_gnt_second", c_gnt, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);

        // CPU write then immediate read of the same address.
        c_req = 1'b1; c_we = 1'b1; c_addr = 9'h010; c_wdata = 8'h5A;
        step(1'b1, 1'b0);
        c_req = 1'b1; c_we = 1'b0;
        step(1'b1, 1'b0);
        check("raw_c_rvalid", c_rvalid, 1'b1);
        check("raw_c_rdata", c_rdata, 8'h5A);
        check("raw_l_rvalid", l_rvalid, 1'b0);
        step(1'b1, 1'b0);

        // Continuous reads from both ports.
        l_req = 1'b1; l_we = 1'b0; l_addr = 9'h003;
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h004;
        for (int i = 0; i < 8; i++) begin
            #1;
`ifdef SRAM_ARB_FIXED_PRI_EN
            check("fixed_l", l_gnt, 1'b1);
`else
            check("alt_l", l_gnt, (i % 2) == 0);
`endif
            step(1'b0, 1'b0);
        end
        l_req = 1'b0; c_req = 1'b0;
        step(1'b0, 1'b0);

        // Loader burst lock starves the CPU until the forced grant.
        l_req = 1'b1; l_lock = 1'b1; l_we = 1'b0; l_addr = 9'h020;
        c_req = 1'b1; c_we = 1'b0; c_addr = 9'h030;
        n_l = 0; got_c = 1'b0; st_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (c_gnt) begin
                got_c = 1'b1;
                st_seen = starved;
            end else if (l_gnt) begin
                n_l++;
            end
            step(1'b0, 1'b0);
            if (got_c) break;
        end
        check("starve_l_grants", n_l, 15);
        check("starve_forced", got_c, 1'b1);
        check("starve_pulse", st_seen, 1'b1);
        c_req = 1'b0;
        step(1'b0, 1'b0);
        l_req = 1'b0; l_lock = 1'b0;
        step(1'b0, 1'b0);

        // Reset right after a loader read grant discards the pending data.
        l_req = 1'b1; l_we = 1'b0; l_addr = 9'h040;
        step(1'b1, 1'b1);
        check("rst_mid_rvalid", l_rvalid, 1'b0);
        check("rst_mid_rdata", l_rdata, 8'h00);
        step(1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b0);

        // Random traffic; requesters hold until granted, occasionally withdrawing.
        for (int i = 0; i < 400; i++) begin
            if (!l_req) begin
                l_req = ($urandom_range(0, 3) != 0);
                l_we = $urandom_range(0, 1);
                l_lock = ($urandom_range(0, 2) == 0);
                l_addr = rand_addr();
                l_wdata = 8'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                l_req = 1'b0;
            end
            if (!c_req) begin
                c_req = ($urandom_range(0, 3) != 0);
                c_we = $urandom_range(0, 1);
                c_addr = rand_addr();
                c_wdata = 8'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                c_req = 1'b0;
            end
            step(1'b1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Cycle-level arbiter sharing the single-port 512x8 instruction/data SRAM between the serial load controller (port L) and the 8-bit serial CPU (port C). It replaces the static load/run multiplexer, so an image can be patched or read back while the CPU runs. Each cycle it grants at most one access, drives the SRAM's active-low CEN/WEN, and routes the registered read data back to the owning requester.

## Interface
- DATA_WIDTH, 8, SRAM word width
- ADDR_WIDTH, 9, SRAM address width
- STARVE_MAX, 15, consecutive denied CPU request cycles before the CPU is force-granted (4-bit counter)
- CLK  in  1  clock; all state updates on its rising edge
- RST_N  in  1  reset, asynchronous, active-low
- L_REQ, L_WE, L_LOCK  in  1 each  loader request, write enable, burst lock
- L_ADDR  in  ADDR_WIDTH  loader address
- L_WDATA  in  DATA_WIDTH  loader write data
- C_REQ, C_WE  in  1 each  CPU request, write enable
- C_ADDR  in  ADDR_WIDTH  CPU address
- C_WDATA  in  DATA_WIDTH  CPU write data
- L_GNT, C_GNT  out  1 each  access accepted this cycle (combinational)
- L_RVALID, C_RVALID  out  1 each  read data valid (registered)
- L_RDATA, C_RDATA  out  DATA_WIDTH  read data, held until the next RVALID for that port
- SRAM_CEN, SRAM_WEN  out  1 each  SRAM chip/write enable, active-low
- SRAM_A  out  ADDR_WIDTH  SRAM address
- SRAM_D  out  DATA_WIDTH  SRAM write data
- SRAM_Q  in  DATA_WIDTH  SRAM read data, valid the cycle after a read access
- STARVED  out  1  pulses for one cycle on each forced CPU grant

## Operation
- State: last_owner (L/C), lock_active, starve_cnt[3:0], rd_pend_L, rd_pend_C.
- Grant decision each cycle, in priority order: (1) starve_cnt == STARVE_MAX and C_REQ -> C; (2) lock_active and L_REQ -> L; (3) only one REQ -> that port; (4) both REQ -> port not equal to last_owner (round robin); (5) neither -> no grant, SRAM_CEN=1, SRAM_WEN=1, SRAM_A=0, SRAM_D=0.
- Granted port drives SRAM_A/SRAM_D; SRAM_CEN=0; SRAM_WEN=!WE.
- On grant: last_owner <= winner. lock_active <= (winner==L) & L_LOCK; cleared when L_LOCK=0 or a forced CPU grant occurs.
- starve_cnt increments (saturating at STARVE_MAX) each cycle C_REQ=1 and C_GNT=0; clears on C_GNT or C_REQ=0.
- Read grant (WE=0) sets rd_pend for that port; next cycle RVALID=1 for exactly one cycle, RDATA <= SRAM_Q. Writes produce no RVALID.
- Requesters hold REQ/ADDR/WE/WDATA stable until GNT; dropping REQ before GNT withdraws the request.
- Reset values: GNTs 0, RVALIDs 0, RDATAs 0, SRAM_CEN=1, SRAM_WEN=1, SRAM_A=0, SRAM_D=0, STARVED 0, last_owner=C (loader wins first tie), lock_active 0, starve_cnt 0. While RST_N=0 all grants forced 0.
- Reset mid-read: pending RVALID is discarded.

## Timing
- Grant latency 0 cycles from REQ when uncontended; max CPU wait STARVE_MAX cycles under lock.
- Read latency: grant in cycle t -> RVALID/RDATA in cycle t+1.
- Back-to-back grants to either port allowed every cycle; alternating L,C,L,C reads give RVALID on alternating ports every cycle.
- Write in cycle t followed by read of same address in t+1 returns the new data.

## Configuration
- SRAM_ARB_FIXED_PRI_EN defined: rule (4) always selects L; last_owner unused for tie-break; starvation rule (1) remains active.
- Not defined: round-robin tie-break as above.

## Test plan
- Reset held, all REQ=1 -> GNTs 0, SRAM_CEN=1; release, both read (L 0x010, C 0x020) -> L granted first, L_RVALID next cycle with Q, then C granted.
- C write 0x05A to 0x010, then C read 0x010 next cycle -> C_RVALID one cycle later, C_RDATA=0x5A, L_RVALID stays 0.
- Both REQ continuously, reads -> grants alternate L,C,L,C; each RVALID on correct port one cycle after grant.
- L_REQ=L_LOCK=1 continuously, C_REQ=1 -> L granted 15 cycles, cycle 16 C_GNT=1 and STARVED pulse, lock cleared, then round robin.
- L read granted then RST_N low before next edge -> L_RVALID never asserts, L_RDATA=0.
- SRAM_ARB_FIXED_PRI_EN defined, both REQ without lock -> L granted every cycle until starve_cnt=15, then one C grant.
